// File: rtl/alt_vipitc131_common_plane_ticker.sv
// Colour-plane sequencer: steps through the planes of one sample and flags
// the cycle on which a whole sample has been delivered.
module alt_vipitc131_common_plane_ticker #(
   parameter int NUMBER_OF_COLOUR_PLANES       = 3,
   parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
   parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    sclr,
   input  logic                                    enable,
   output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
   output logic                                    start_of_sample,
   output logic                                    count_sample
);

   localparam bit PARALLEL = (COLOUR_PLANES_ARE_IN_PARALLEL != 0);
   localparam logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] LAST_TICK =
      LOG2_NUMBER_OF_COLOUR_PLANES'(NUMBER_OF_COLOUR_PLANES - 1);

   logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] ticks_q, ticks_d;
   logic                                    last_plane;

   assign last_plane = (ticks_q == LAST_TICK);

   always_comb begin
      ticks_d = ticks_q;
      if (sclr) begin
         ticks_d = '0;
      end else if (enable && !PARALLEL) begin
         ticks_d = last_plane ? '0 : ticks_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ticks_q <= '0;
      end else begin
         ticks_q <= ticks_d;
      end
   end

   assign sample_ticks    = ticks_q;
   assign start_of_sample = (ticks_q == '0);
   // Gated by rst so no downstream strobe can fire while reset is held.
   assign count_sample    = !rst && enable && (PARALLEL || last_plane);

endmodule

// File: rtl/alt_vipitc131_common_field_frame_counter.sv
// Raster position counter: horizontal/vertical counts, field tracking and
// line/field/frame strobes, with totals latched only at frame boundaries.
module alt_vipitc131_common_field_frame_counter #(
   parameter int H_WIDTH                       = 14,
   parameter int V_WIDTH                       = 13,
   parameter int NUMBER_OF_COLOUR_PLANES       = 3,
   parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
   parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
   parameter int TOTALS_MINUS_ONE              = 0,
   parameter int INTERLACED                    = 0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    sclr,
   input  logic                                    enable,
   input  logic [H_WIDTH-1:0]                      h_total,
   input  logic [V_WIDTH-1:0]                      v_total_f0,
   input  logic [V_WIDTH-1:0]                      v_total_f1,
   input  logic [H_WIDTH-1:0]                      h_reset,
   input  logic [V_WIDTH-1:0]                      v_reset,
   input  logic                                    field_reset,
   output logic [H_WIDTH-1:0]                      h_count,
   output logic [V_WIDTH-1:0]                      v_count,
   output logic                                    field,
   output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
   output logic                                    start_of_sample,
   output logic                                    new_line,
   output logic                                    end_of_field,
   output logic                                    new_frame
);

   localparam bit IL = (INTERLACED != 0);

   function automatic logic [H_WIDTH-1:0] h_active_total(input logic [H_WIDTH-1:0] t);
      return (TOTALS_MINUS_ONE != 0) ? t : t - 1'b1;
   endfunction

   function automatic logic [V_WIDTH-1:0] v_active_total(input logic [V_WIDTH-1:0] t);
      return (TOTALS_MINUS_ONE != 0) ? t : t - 1'b1;
   endfunction

   logic               count_sample;
   logic [H_WIDTH-1:0] h_count_q, h_count_d;
   logic [V_WIDTH-1:0] v_count_q, v_count_d;
   logic               field_q, field_d;
   logic [H_WIDTH-1:0] h_tot_a_q, h_tot_a_d;
   logic [V_WIDTH-1:0] vf0_tot_a_q, vf0_tot_a_d;
   logic [V_WIDTH-1:0] vf1_tot_a_q, vf1_tot_a_d;
   logic [V_WIDTH-1:0] v_tot_sel;
   logic               load_totals;

   alt_vipitc131_common_plane_ticker #(
      .NUMBER_OF_COLOUR_PLANES      (NUMBER_OF_COLOUR_PLANES),
      .COLOUR_PLANES_ARE_IN_PARALLEL(COLOUR_PLANES_ARE_IN_PARALLEL),
      .LOG2_NUMBER_OF_COLOUR_PLANES (LOG2_NUMBER_OF_COLOUR_PLANES)
   ) u_ticker (
      .clk            (clk),
      .rst            (rst),
      .sclr           (sclr),
      .enable         (enable),
      .sample_ticks   (sample_ticks),
      .start_of_sample(start_of_sample),
      .count_sample   (count_sample)
   );

   // >= rather than == so counts left above a shrunken total still wrap.
   assign v_tot_sel    = field_q ? vf1_tot_a_q : vf0_tot_a_q;
   assign new_line     = count_sample && (h_count_q >= h_tot_a_q);
   assign end_of_field = new_line && (v_count_q >= v_tot_sel);
   assign new_frame    = end_of_field && (!IL || field_q);
   assign load_totals  = sclr || new_frame;

   always_comb begin
      h_count_d   = h_count_q;
      v_count_d   = v_count_q;
      field_d     = field_q;
      h_tot_a_d   = h_tot_a_q;
      vf0_tot_a_d = vf0_tot_a_q;
      vf1_tot_a_d = vf1_tot_a_q;
      if (sclr) begin
         h_count_d = h_reset;
         v_count_d = v_reset;
         field_d   = field_reset && IL;
      end else if (count_sample) begin
         if (new_line) begin
            h_count_d = '0;
            if (end_of_field) begin
               v_count_d = '0;
               field_d   = IL ? !field_q : 1'b0;
            end else begin
               v_count_d = v_count_q + 1'b1;
            end
         end else begin
            h_count_d = h_count_q + 1'b1;
         end
      end
      if (load_totals) begin
         h_tot_a_d   = h_active_total(h_total);
         vf0_tot_a_d = v_active_total(v_total_f0);
         vf1_tot_a_d = v_active_total(v_total_f1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_count_q   <= '0;
         v_count_q   <= '0;
         field_q     <= 1'b0;
         h_tot_a_q   <= '0;
         vf0_tot_a_q <= '0;
         vf1_tot_a_q <= '0;
      end else begin
         h_count_q   <= h_count_d;
         v_count_q   <= v_count_d;
         field_q     <= field_d;
         h_tot_a_q   <= h_tot_a_d;
         vf0_tot_a_q <= vf0_tot_a_d;
         vf1_tot_a_q <= vf1_tot_a_d;
      end
   end

   assign h_count = h_count_q;
   assign v_count = v_count_q;
   assign field   = field_q;

endmodule

// File: doc/alt_vipitc131_common_field_frame_counter.md
ALT_VIPITC131_COMMON_FIELD_FRAME_COUNTER -- requirements
Module: alt_vipitc131_common_field_frame_counter

Interface
REQ-001 SHALL have parameter H_WIDTH, default 14, horizontal counter/total width.
REQ-002 SHALL have parameter V_WIDTH, default 13, vertical counter/total width.
REQ-003 SHALL have parameter NUMBER_OF_COLOUR_PLANES, default 3, planes per sample.
REQ-004 SHALL have parameter COLOUR_PLANES_ARE_IN_PARALLEL, default 1, 1 = one sample per enabled cycle.
REQ-005 SHALL have parameter LOG2_NUMBER_OF_COLOUR_PLANES, default 2, width of sample_ticks.
REQ-006 SHALL have parameter TOTALS_MINUS_ONE, default 0, 1 = totals inputs already hold total-1.
REQ-007 SHALL have parameter INTERLACED, default 0, 1 = two fields per frame.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset; sclr in 1 synchronous clear/load; enable in 1 cycle qualifier.
REQ-009 SHALL have ports: h_total in H_WIDTH; v_total_f0 in V_WIDTH; v_total_f1 in V_WIDTH (ignored when INTERLACED=0); h_reset in H_WIDTH; v_reset in V_WIDTH; field_reset in 1.
REQ-010 SHALL have outputs: h_count H_WIDTH reg; v_count V_WIDTH reg; field 1 reg; sample_ticks LOG2_NUMBER_OF_COLOUR_PLANES reg; start_of_sample 1; new_line 1; end_of_field 1; new_frame 1.

Function
REQ-011 Sequential planes: sample_ticks SHALL advance 0..NUMBER_OF_COLOUR_PLANES-1 on each enable cycle, wrapping to 0; held when enable=0.
REQ-012 Parallel planes: sample_ticks SHALL stay 0.
REQ-013 start_of_sample SHALL be combinational: sample_ticks==0.
REQ-014 count_sample (internal) SHALL be enable AND (parallel OR sample_ticks==NUMBER_OF_COLOUR_PLANES-1).
REQ-015 Active totals SHALL be held in internal registers h_tot_a, vf0_tot_a, vf1_tot_a, loaded from inputs on sclr and on the cycle new_frame=1; input changes at other times SHALL have no effect until then.
REQ-016 With TOTALS_MINUS_ONE=0 the loaded value SHALL be input-1 modulo 2^width (input 0 yields all-ones); otherwise input unchanged.
REQ-017 new_line SHALL be combinational: count_sample AND h_count >= h_tot_a.
REQ-018 end_of_field SHALL be combinational: new_line AND v_count >= active field's vertical total (field 0 -> vf0_tot_a, field 1 -> vf1_tot_a).
REQ-019 new_frame SHALL be combinational: end_of_field AND (INTERLACED=0 OR field=1).
REQ-020 On count_sample without new_line, h_count SHALL increment by 1.
REQ-021 On new_line, h_count SHALL go to 0; v_count SHALL increment, or go to 0 on end_of_field.
REQ-022 On end_of_field with INTERLACED=1, field SHALL toggle; with INTERLACED=0 field SHALL stay 0.
REQ-023 Counts above the active total (after sclr or total change) SHALL wrap at the next qualifying count_sample via the >= compare, never overflow-scan.
REQ-024 sclr SHALL take priority over enable: h_count<=h_reset, v_count<=v_reset, field<=field_reset AND INTERLACED, sample_ticks<=0, totals reloaded.
REQ-025 enable=0 without sclr SHALL hold all registers; combinational strobes SHALL be 0.
REQ-026 Latency: strobes SHALL be asserted in the same cycle as the qualifying count_sample; counter update visible next cycle.

Reset
REQ-027 rst SHALL asynchronously clear h_count, v_count, field, sample_ticks and all active-total registers to 0.
REQ-028 With totals 0 after reset, new_line and end_of_field SHALL assert on every count_sample until sclr loads totals.
REQ-029 rst asserted mid-frame SHALL abort counting immediately; no strobe SHALL assert while rst=1.

Structure
REQ-030 The plane sequencer (REQ-011..014) SHALL be the sub-module alt_vipitc131_common_plane_ticker.
REQ-031 No shared package; width and mode constants SHALL remain module parameters.

Verification
REQ-032 Parallel, h_total=4, v_total_f0=3, sclr then enable constant -> h 0..3, new_line every 4th cycle, new_frame every 12th cycle, v 0..2.
REQ-033 Sequential 3 planes, h_total=2, v_total_f0=2 -> count_sample every 3rd cycle, new_frame at cycle 12, start_of_sample at ticks 0.
REQ-034 INTERLACED=1, h_total=2, v_total_f0=3, v_total_f1=2 -> end_of_field at cycles 6 and 10, new_frame only at 10, field 0->1->0.
REQ-035 Change h_total 4->6 mid-frame -> line length stays 4 until new_frame, 6 afterwards.
REQ-036 sclr with h_reset=10 > h_total-1=3, enable -> new_line next count_sample, h_count 0.
REQ-037 rst pulse mid-line with enable=1 -> all outputs 0 asynchronously, new_line every sample until sclr.
